gpc_fetch_ctrl: RTL and testbench
=================================

// Module: gpc_fetch_ctrl
// PURPOSE
//   Instruction-fetch sequencer for the GPC32 core. Drives a req/ack handshake to instruction memory at the PC address.
//   Captures the returned word and issues a one-cycle step enable that advances PC and commits the register write.
//   Turns the single-cycle core into a memory-latency-tolerant fetch/execute loop with start/halt control.
// PARAMETERS
//   WIDTH          32            address/data width of PC
//   INST_MAX       32            instruction word width
//   TIMEOUT_CYCLES 16            max REQ cycles without ack (used only with GPC_FETCH_TIMEOUT_EN); must be >=2
// PORTS
//   clk          in   1         single clock, all state updates on rising edge
//   rst          in   1         synchronous, active-high reset
//   start        in   1         leave IDLE/HALTED and begin fetching; ignored while busy
//   halt         in   1         stop after the instruction currently in flight commits
//   pc_in        in   WIDTH     current PC (changes only on the edge that ends a step cycle)
//   mem_req      out  1         fetch request to instruction memory
//   mem_addr     out  WIDTH     fetch address = pc_in (combinational)
//   mem_ack      in   1         memory returns mem_rdata this cycle
//   mem_rdata    in   INST_MAX  fetched instruction word
//   inst         out  INST_MAX  captured instruction to IDU, held until next capture
//   step         out  1         one-cycle enable: PC update + register write this cycle
//   busy         out  1         high in REQ and EXEC
//   addr_err     out  1         sticky: misaligned PC detected
//   timeout_err  out  1         sticky: fetch timeout (tied 0 without macro)
// BEHAVIOUR
//   Reset: state=IDLE, mem_req=0, step=0, busy=0, inst=NOP (32'h0000_0013), addr_err=0, timeout_err=0.
//   FSM states: IDLE, REQ, EXEC, HALTED.
//   IDLE/HALTED --start--> REQ; start clears addr_err and timeout_err.
//   REQ: if pc_in[1:0]!=0: mem_req=0, set addr_err, -> HALTED. Otherwise mem_req=1.
//     Request stays high with mem_addr stable until mem_ack=1.
//     On mem_req&&mem_ack: inst<=mem_rdata, -> EXEC.
//   EXEC: step=1 for exactly one cycle, mem_req=0. Then -> HALTED if halt was latched, else -> REQ.
//   Throughput: zero-wait memory (ack in first REQ cycle) gives 2 cycles/instruction. Each wait cycle adds 1.
//   halt: latched into halt_pend in any state; cleared on entry to HALTED or by reset.
//     An outstanding request is never abandoned: halt in REQ completes ack+EXEC, then HALTED.
//   mem_ack outside REQ is ignored; inst is not updated.
//   start and halt in the same cycle from IDLE: go to REQ, execute one instruction, then HALTED.
//   Reset mid-handshake: mem_req drops on the reset edge. A late ack afterwards is ignored.
//   inst is written only on an accepted ack. step is never high in two consecutive cycles.
// CONFIGURATION
//   GPC_FETCH_TIMEOUT_EN defined:
//     wait counter cleared on REQ entry, increments each REQ cycle without ack.
//     If ack is still absent in the TIMEOUT_CYCLES-th REQ cycle: mem_req drops on the next edge, timeout_err set, -> HALTED.
//     An ack arriving in that final cycle is still accepted.
//   GPC_FETCH_TIMEOUT_EN undefined: REQ waits indefinitely, no counter is built, timeout_err is constant 0.
// STRUCTURE
//   gpc_pkg (shared package):
//     fetch_state_t enum IDLE=2'd0, REQ=2'd1, EXEC=2'd2, HALTED=2'd3
//     GPC_NOP constant 32'h0000_0013
//   One sub-module, gpc_fetch_timer: timeout counter, width $clog2(TIMEOUT_CYCLES+1).
//     Ports: clr, inc, expired. Instantiated only under GPC_FETCH_TIMEOUT_EN.
// TESTING
//   1. rst, then start with pc_in=32'h8000_0000 and ack in first REQ cycle, rdata=32'h0010_0093
//      -> mem_req 1 cycle, inst=32'h0010_0093, step pulse next cycle, new REQ the cycle after.
//   2. ack delayed 3 cycles with pc_in=32'h8000_0004 -> mem_req high and mem_addr stable for 4 cycles, single step after ack.
//   3. halt asserted mid-REQ -> ack accepted, one step, then HALTED with busy=0.
//      start -> fetch resumes at the current pc_in.
//   4. pc_in=32'h8000_0002 on REQ entry -> mem_req stays 0, addr_err=1, HALTED, no step. start clears addr_err.
//   5. rst asserted while mem_req=1, ack pulsed next cycle -> mem_req=0, inst stays NOP, no step.
//   6. [GPC_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16] no ack -> mem_req high 16 cycles, then timeout_err=1, HALTED.
//      Ack in cycle 16 -> normal EXEC, no error.

Source files
------------

// File: rtl/gpc_pkg.sv
// rtl/gpc_pkg.sv - shared fetch FSM state encoding and NOP constant for the GPC32 fetch controller
package gpc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam logic [31:0] GPC_NOP = 32'h0000_0013;

endpackage

// File: rtl/gpc_fetch_ctrl_if.sv
// rtl/gpc_fetch_ctrl_if.sv - instruction memory req/ack fetch bus
interface gpc_fetch_ctrl_if #(
    parameter int WIDTH    = 32,
    parameter int INST_MAX = 32
) ();

    logic                mem_req;
    logic [WIDTH-1:0]    mem_addr;
    logic                mem_ack;
    logic [INST_MAX-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/gpc_fetch_timer.sv
// rtl/gpc_fetch_timer.sv - REQ wait counter; expired flags the last permitted REQ cycle
module gpc_fetch_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // cnt holds the number of REQ cycles already spent without an ack
    assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gpc_fetch_ctrl.sv
// rtl/gpc_fetch_ctrl.sv - GPC32 fetch/execute sequencer; GPC_FETCH_TIMEOUT_EN adds the REQ timeout
module gpc_fetch_ctrl
    import gpc_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int INST_MAX       = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                halt,
    input  logic [WIDTH-1:0]    pc_in,
    gpc_fetch_ctrl_if.master    mem,
    output logic [INST_MAX-1:0] inst,
    output logic                step,
    output logic                busy,
    output logic                addr_err,
    output logic                timeout_err
);

    fetch_state_t state, state_nxt;
    logic         halt_pend;
    logic         aligned;
    logic         accept;
    logic         start_ok;
    logic         expired;

    assign aligned       = (pc_in[1:0] == 2'b00);
    assign accept        = mem.mem_req && mem.mem_ack;
    assign start_ok      = ((state == IDLE) || (state == HALTED)) && start;
    assign mem.mem_addr  = pc_in;

`ifdef GPC_FETCH_TIMEOUT_EN
    gpc_fetch_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != REQ),
        .inc     ((state == REQ) && !accept),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (start_ok) begin
            timeout_err <= 1'b0;
        end else if ((state == REQ) && aligned && !accept && expired) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign expired            = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALTED: if (start) state_nxt = REQ;
            REQ: begin
                if (!aligned)     state_nxt = HALTED;
                else if (accept)  state_nxt = EXEC;
                else if (expired) state_nxt = HALTED;
            end
            // a halt arriving during the commit cycle still stops after this instruction
            EXEC:    state_nxt = (halt_pend || halt) ? HALTED : REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req = (state == REQ) && aligned;
        step        = (state == EXEC);
        busy        = (state == REQ) || (state == EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst      <= INST_MAX'(GPC_NOP);
            halt_pend <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            if (accept) begin
                inst <= mem.mem_rdata;
            end
            if ((state_nxt == HALTED) && (state != HALTED)) begin
                halt_pend <= 1'b0;
            end else begin
                halt_pend <= halt_pend || halt;
            end
            if (start_ok) begin
                addr_err <= 1'b0;
            end else if ((state == REQ) && !aligned) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpc_fetch_ctrl.sv
// tb/tb_gpc_fetch_ctrl.sv - directed vector table, timeout sequence and randomized model check for gpc_fetch_ctrl
module tb_gpc_fetch_ctrl;
    import gpc_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halt;
    logic [31:0] pc_in;
    logic [31:0] inst;
    logic        step;
    logic        busy;
    logic        addr_err;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    gpc_fetch_ctrl_if #(.WIDTH(32), .INST_MAX(32)) bus ();

    gpc_fetch_ctrl #(
        .WIDTH          (32),
        .INST_MAX       (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt        (halt),
        .pc_in       (pc_in),
        .mem         (bus.master),
        .inst        (inst),
        .step        (step),
        .busy        (busy),
        .addr_err    (addr_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, s, h, a;
        logic [31:0] pc, rd;
        logic        req, stp, bsy, aerr;
        logic [31:0] ins;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic r, s, h, a, input logic [31:0] pc, rd,
                               input logic req, stp, bsy, aerr, input logic [31:0] ins);
        vec_t x;
        x.r = r; x.s = s; x.h = h; x.a = a; x.pc = pc; x.rd = rd;
        x.req = req; x.stp = stp; x.bsy = bsy; x.aerr = aerr; x.ins = ins;
        return x;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic put(input logic r, s, h, a, input logic [31:0] p, rd);
        rst = r; start = s; halt = h; bus.mem_ack = a; pc_in = p; bus.mem_rdata = rd;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic req, stp, bsy, aerr, terr,
                           input logic [31:0] ins);
        chk1({tag, ".mem_req"}, bus.mem_req, req);
        chk1({tag, ".step"}, step, stp);
        chk1({tag, ".busy"}, busy, bsy);
        chk1({tag, ".addr_err"}, addr_err, aerr);
        chk1({tag, ".timeout_err"}, timeout_err, terr);
        chk32({tag, ".inst"}, inst, ins);
        chk32({tag, ".mem_addr"}, bus.mem_addr, pc_in);
    endtask

    // behavioural model state
    logic        m_run, m_exec, m_pend, m_aerr, m_terr;
    logic [31:0] m_inst;
    int          m_wait;

    initial begin
        logic [31:0] P0, P4, P8, PC, P2, P10, P14, NOP;
        P0 = 32'h8000_0000; P4 = 32'h8000_0004; P8 = 32'h8000_0008; PC = 32'h8000_000C;
        P2 = 32'h8000_0002; P10 = 32'h8000_0010; P14 = 32'h8000_0014; NOP = GPC_NOP;

        //                 r  s  h  a  pc   rdata          req stp bsy aerr inst
        vt.push_back(v(1, 0, 0, 0, P0,  32'h0,          0, 0, 0, 0, NOP));
        vt.push_back(v(0, 1, 0, 0, P0,  32'h0,          0, 0, 0, 0, NOP));
        vt.push_back(v(0, 0, 0, 1, P0,  32'h0010_0093,  1, 0, 1, 0, NOP));
        vt.push_back(v(0, 0, 0, 0, P0,  32'h0,          0, 1, 1, 0, 32'h0010_0093));
        vt.push_back(v(0, 0, 0, 0, P4,  32'h0,          1, 0, 1, 0, 32'h0010_0093));
        vt.push_back(v(0, 0, 0, 0, P4,  32'h0,          1, 0, 1, 0, 32'h0010_0093));
        vt.push_back(v(0, 0, 0, 0, P4,  32'h0,          1, 0, 1, 0, 32'h0010_0093));
        vt.push_back(v(0, 0, 0, 1, P4,  32'h0020_0113,  1, 0, 1, 0, 32'h0010_0093));
        vt.push_back(v(0, 0, 0, 0, P4,  32'h0,          0, 1, 1, 0, 32'h0020_0113));
        vt.push_back(v(0, 0, 1, 0, P8,  32'h0,          1, 0, 1, 0, 32'h0020_0113));
        vt.push_back(v(0, 0, 0, 1, P8,  32'h0030_0193,  1, 0, 1, 0, 32'h0020_0113));
        vt.push_back(v(0, 0, 0, 0, P8,  32'h0,          0, 1, 1, 0, 32'h0030_0193));
        vt.push_back(v(0, 0, 0, 0, PC,  32'h0,          0, 0, 0, 0, 32'h0030_0193));
        vt.push_back(v(0, 0, 0, 1, PC,  32'hDEAD_BEEF,  0, 0, 0, 0, 32'h0030_0193));
        vt.push_back(v(0, 1, 0, 0, PC,  32'h0,          0, 0, 0, 0, 32'h0030_0193));
        vt.push_back(v(0, 0, 0, 1, PC,  32'h0040_0213,  1, 0, 1, 0, 32'h0030_0193));
        vt.push_back(v(0, 0, 1, 0, PC,  32'h0,          0, 1, 1, 0, 32'h0040_0213));
        vt.push_back(v(0, 1, 0, 0, P2,  32'h0,          0, 0, 0, 0, 32'h0040_0213));
        vt.push_back(v(0, 0, 0, 1, P2,  32'h0,          0, 0, 1, 0, 32'h0040_0213));
        vt.push_back(v(0, 0, 0, 0, P2,  32'h0,          0, 0, 0, 1, 32'h0040_0213));
        vt.push_back(v(0, 1, 0, 0, P10, 32'h0,          0, 0, 0, 1, 32'h0040_0213));
        vt.push_back(v(0, 0, 0, 0, P10, 32'h0,          1, 0, 1, 0, 32'h0040_0213));
        vt.push_back(v(1, 0, 0, 0, P10, 32'h0,          1, 0, 1, 0, 32'h0040_0213));
        vt.push_back(v(0, 0, 0, 1, P10, 32'h1111_1111,  0, 0, 0, 0, NOP));
        vt.push_back(v(0, 1, 1, 0, P10, 32'h0,          0, 0, 0, 0, NOP));
        vt.push_back(v(0, 0, 0, 1, P10, 32'h0050_0293,  1, 0, 1, 0, NOP));
        vt.push_back(v(0, 0, 0, 0, P10, 32'h0,          0, 1, 1, 0, 32'h0050_0293));
        vt.push_back(v(0, 0, 0, 0, P14, 32'h0,          0, 0, 0, 0, 32'h0050_0293));

        put(1, 0, 0, 0, P0, 32'h0);
        adv();

        for (int i = 0; i < vt.size(); i++) begin
            put(vt[i].r, vt[i].s, vt[i].h, vt[i].a, vt[i].pc, vt[i].rd);
            chk_all($sformatf("vec%0d", i), vt[i].req, vt[i].stp, vt[i].bsy, vt[i].aerr,
                    1'b0, vt[i].ins);
            adv();
        end

`ifdef GPC_FETCH_TIMEOUT_EN
        put(1, 0, 0, 0, P0, 32'h0);
        adv();
        put(0, 1, 0, 0, P0, 32'h0);
        adv();
        for (int c = 1; c <= TO; c++) begin
            put(0, 0, 0, 0, P0, 32'h0);
            chk_all($sformatf("to_wait%0d", c), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NOP);
            adv();
        end
        put(0, 0, 0, 1, P0, 32'h0);
        chk_all("to_expired", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NOP);
        adv();
        put(0, 1, 0, 0, P0, 32'h0);
        chk_all("to_restart", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NOP);
        adv();
        for (int c = 1; c < TO; c++) begin
            put(0, 0, 0, 0, P0, 32'h0);
            adv();
        end
        put(0, 0, 0, 1, P0, 32'h0060_0313);
        chk_all("to_last_ack", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NOP);
        adv();
        put(0, 0, 0, 0, P0, 32'h0);
        chk_all("to_last_exec", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0060_0313);
        adv();
`endif

        // randomized run against the behavioural model
        put(1, 0, 0, 0, P0, 32'h0);
        adv();
        m_run = 0; m_exec = 0; m_pend = 0; m_aerr = 0; m_terr = 0; m_inst = NOP; m_wait = 0;
        pc_in = P0;
        for (int n = 0; n < 2000; n++) begin
            logic r, s, h, a, e_req, e_step, down, pend_in;
            logic [31:0] rd;
            r  = ($urandom % 64) == 0;
            s  = ($urandom % 6) == 0;
            h  = ($urandom % 12) == 0;
            a  = $urandom % 2;
            rd = $urandom;
            put(r, s, h, a, pc_in, rd);
            e_step = m_run && m_exec;
            e_req  = m_run && !m_exec && (pc_in[1:0] == 2'b00);
            chk_all($sformatf("rnd%0d", n), e_req, e_step, m_run, m_aerr, m_terr, m_inst);

            if (r) begin
                m_run = 0; m_exec = 0; m_pend = 0; m_aerr = 0; m_terr = 0;
                m_inst = NOP; m_wait = 0;
            end else begin
                down    = 0;
                pend_in = m_pend || h;
                if (!m_run) begin
                    if (s) begin
                        m_run = 1; m_exec = 0; m_aerr = 0; m_terr = 0; m_wait = 0;
                    end
                end else if (m_exec) begin
                    if (pend_in) down = 1;
                    m_exec = 0;
                    m_wait = 0;
                end else if (pc_in[1:0] != 2'b00) begin
                    m_aerr = 1;
                    down   = 1;
                end else if (a) begin
                    m_inst = rd;
                    m_exec = 1;
                end else begin
                    m_wait++;
`ifdef GPC_FETCH_TIMEOUT_EN
                    if (m_wait == TO) begin
                        m_terr = 1;
                        down   = 1;
                    end
`endif
                end
                m_pend = down ? 1'b0 : pend_in;
                if (down) m_run = 0;
            end
            adv();

            if (e_step && !r) begin
                pc_in = pc_in + ((($urandom % 10) == 0) ? 32'd2 : 32'd4);
            end else if (!m_run && (($urandom % 4) == 0)) begin
                pc_in = {$urandom, 2'b00} >> 2 << 2;
                if (($urandom % 8) == 0) pc_in[1] = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
